// File: rtl/cpu_pkg.sv
// Shared definitions for the decode-side control-flow logic: widths, opcodes,
// resolver state encoding and a saturating-increment helper.
package cpu_pkg;

   localparam int PC_W   = 16;
   localparam int INST_W = 9;

   localparam logic [3:0] OP_BRT    = 4'b1100;
   localparam logic [3:0] OP_BRF    = 4'b1101;
   localparam logic [3:0] OP_JMP    = 4'b1110;
   localparam logic [3:0] OP_HALT   = 4'b1111;
   localparam logic [4:0] HALT_TAIL = 5'b11111;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_STALL,
      ST_FLUSH,
      ST_HALTED
   } bru_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute-facing bundle of the branch resolve unit.
// BRANCH_STATS_EN adds the taken/stall statistics counters to the bundle.
interface branch_resolve_unit_if;
   import cpu_pkg::*;

   logic [INST_W-1:0] fetched_instruction;
   logic [PC_W-1:0]   fetch_pc;
   logic              flag;
   logic              flag_busy;
   logic [PC_W-1:0]   pc_feedback;
   logic              branch;
   logic              taken;
   logic              jump_sign;
   logic [PC_W-1:0]   target;
   logic              halt;
   logic              stall;
   logic [INST_W-1:0] id_instruction;
   logic [PC_W-1:0]   id_pc;
   logic              id_valid;
`ifdef BRANCH_STATS_EN
   logic [15:0]       taken_count;
   logic [15:0]       stall_count;
`endif

   modport master (
      output fetched_instruction, fetch_pc, flag, flag_busy,
      input  pc_feedback, branch, taken, jump_sign, target, halt, stall,
      input  id_instruction, id_pc, id_valid
`ifdef BRANCH_STATS_EN
      , input taken_count, stall_count
`endif
   );

   modport slave (
      input  fetched_instruction, fetch_pc, flag, flag_busy,
      output pc_feedback, branch, taken, jump_sign, target, halt, stall,
      output id_instruction, id_pc, id_valid
`ifdef BRANCH_STATS_EN
      , output taken_count, stall_count
`endif
   );

endinterface

// File: rtl/branch_decoder.sv
// Combinational classifier for the control-flow opcodes of a 9-bit instruction.
module branch_decoder
   import cpu_pkg::*;
(
   input  logic [INST_W-1:0] instruction,
   output logic              is_cond,
   output logic              is_jmp,
   output logic              is_halt,
   output logic              sign,
   output logic [PC_W-1:0]   offset
);

   logic [3:0] op;

   assign op      = instruction[8:5];
   assign is_cond = (op == OP_BRT) || (op == OP_BRF);
   assign is_jmp  = (op == OP_JMP);
   assign is_halt = (op == OP_HALT) && (instruction[4:0] == HALT_TAIL);
   assign sign    = instruction[4];
   assign offset  = {{(PC_W-4){1'b0}}, instruction[3:0]};

endmodule

// File: rtl/branch_resolve_unit.sv
// IF/ID register plus branch resolution FSM (stall on flag hazard, squash after taken).
// Optional BRANCH_STATS_EN adds saturating taken/stall counters.
module branch_resolve_unit
   import cpu_pkg::*;
#(
   parameter int FLUSH_SLOTS = 1
)
(
   input logic                  clk,
   input logic                  init,
   branch_resolve_unit_if.slave bus
);

   localparam logic [1:0] FLUSH_CNT_INIT = 2'(FLUSH_SLOTS - 1);

   bru_state_t        state_reg, state_next;
   logic [1:0]        flush_cnt_reg, flush_cnt_next;
   logic              started_reg, started_next;
   logic [INST_W-1:0] id_inst_reg, id_inst_next;
   logic [PC_W-1:0]   id_pc_reg, id_pc_next;
   logic              id_valid_reg, id_valid_next;
   logic [PC_W-1:0]   pc_fb_reg, pc_fb_next;
   logic              branch_reg, branch_next;
   logic              taken_reg, taken_next;
   logic              sign_reg, sign_next;
   logic [PC_W-1:0]   target_reg, target_next;
   logic              halt_reg, halt_next;
   logic              stall_reg, stall_next;

   logic              is_cond, is_jmp, is_halt, sign;
   logic [PC_W-1:0]   offset;
   logic              resolve, advance, squash, taken_now;

   branch_decoder u_decoder (
      .instruction (id_inst_reg),
      .is_cond     (is_cond),
      .is_jmp      (is_jmp),
      .is_halt     (is_halt),
      .sign        (sign),
      .offset      (offset)
   );

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         state_reg     <= ST_RUN;
         flush_cnt_reg <= '0;
         started_reg   <= 1'b0;
         id_inst_reg   <= '0;
         id_pc_reg     <= '0;
         id_valid_reg  <= 1'b0;
         pc_fb_reg     <= '0;
         branch_reg    <= 1'b0;
         taken_reg     <= 1'b0;
         sign_reg      <= 1'b0;
         target_reg    <= '0;
         halt_reg      <= 1'b0;
         stall_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         flush_cnt_reg <= flush_cnt_next;
         started_reg   <= started_next;
         id_inst_reg   <= id_inst_next;
         id_pc_reg     <= id_pc_next;
         id_valid_reg  <= id_valid_next;
         pc_fb_reg     <= pc_fb_next;
         branch_reg    <= branch_next;
         taken_reg     <= taken_next;
         sign_reg      <= sign_next;
         target_reg    <= target_next;
         halt_reg      <= halt_next;
         stall_reg     <= stall_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      flush_cnt_next = flush_cnt_reg;
      started_next   = 1'b1;
      id_inst_next   = id_inst_reg;
      id_pc_next     = id_pc_reg;
      id_valid_next  = 1'b0;
      pc_fb_next     = pc_fb_reg;
      branch_next    = 1'b0;
      taken_next     = 1'b0;
      sign_next      = sign_reg;
      target_next    = target_reg;
      halt_next      = halt_reg;
      stall_next     = 1'b0;
      resolve        = 1'b0;
      advance        = 1'b0;
      squash         = 1'b0;

      unique case (state_reg)
         ST_RUN: begin
            if (id_valid_reg && is_halt) begin
               state_next = ST_HALTED;
               halt_next  = 1'b1;
            end else if (id_valid_reg && is_cond && bus.flag_busy) begin
               state_next = ST_STALL;
               stall_next = 1'b1;
            end else if (id_valid_reg && (is_cond || is_jmp)) begin
               resolve = 1'b1;
            end else begin
               // The first fetch after reset is not yet a real instruction.
               advance = 1'b1;
               squash  = ~started_reg;
            end
         end
         ST_STALL: begin
            if (bus.flag_busy) stall_next = 1'b1;
            else               resolve    = 1'b1;
         end
         ST_FLUSH: begin
            advance        = 1'b1;
            squash         = 1'b1;
            flush_cnt_next = flush_cnt_reg - 2'd1;
            if (flush_cnt_reg <= 2'd1) begin
               state_next     = ST_RUN;
               flush_cnt_next = '0;
            end
         end
         default: ;
      endcase

      // Opcode bit 5 separates BRF (taken on flag low) from BRT.
      taken_now = resolve && (is_jmp || (id_inst_reg[5] ? ~bus.flag : bus.flag));

      if (resolve) begin
         advance     = 1'b1;
         branch_next = 1'b1;
         taken_next  = taken_now;
         sign_next   = sign;
         target_next = offset;
         state_next  = ST_RUN;
         if (taken_now) begin
            squash = 1'b1;
            if (FLUSH_CNT_INIT != 2'd0) begin
               state_next     = ST_FLUSH;
               flush_cnt_next = FLUSH_CNT_INIT;
            end
         end
      end

      if (advance) begin
         id_inst_next  = bus.fetched_instruction;
         id_pc_next    = bus.fetch_pc;
         id_valid_next = ~squash;
         pc_fb_next    = taken_now ? id_pc_reg : bus.fetch_pc;
      end
   end

   assign bus.pc_feedback    = pc_fb_reg;
   assign bus.branch         = branch_reg;
   assign bus.taken          = taken_reg;
   assign bus.jump_sign      = sign_reg;
   assign bus.target         = target_reg;
   assign bus.halt           = halt_reg;
   assign bus.stall          = stall_reg;
   assign bus.id_instruction = id_inst_reg;
   assign bus.id_pc          = id_pc_reg;
   assign bus.id_valid       = id_valid_reg;

`ifdef BRANCH_STATS_EN
   logic [15:0] taken_cnt_reg, stall_cnt_reg;

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         taken_cnt_reg <= '0;
         stall_cnt_reg <= '0;
      end else begin
         if (taken_now)              taken_cnt_reg <= sat_inc16(taken_cnt_reg);
         if (state_reg == ST_STALL)  stall_cnt_reg <= sat_inc16(stall_cnt_reg);
      end
   end

   assign bus.taken_count = taken_cnt_reg;
   assign bus.stall_count = stall_cnt_reg;
`endif

endmodule
